// File: rtl/readback_framer_pkg.sv
// Shared definitions for the readback framer: FSM encoding, marker defaults
// and the bit positions of the fields inside a frame word.
package readback_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  localparam logic [7:0] HDR_MARK_DEF = 8'hA5;
  localparam logic [7:0] TRL_MARK_DEF = 8'h5A;

  // Field offsets within a 32-bit frame word.
  localparam int MARK_LSB = 24;
  localparam int SEQ_LSB  = 16;
  localparam int TAG_LSB  = 24;
  localparam int IDX_LSB  = 16;
  localparam int CNT_LSB  = 8;

endpackage

// File: rtl/readback_framer.sv
// Packs readback items into header / payload / trailer words and writes them
// into the readback FIFO, honouring wrfull backpressure.
module readback_framer
  import readback_framer_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 64,
  parameter logic [7:0] HDR_MARK    = HDR_MARK_DEF,
  parameter logic [7:0] TRL_MARK    = TRL_MARK_DEF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        rb_valid,
  output logic        rb_ready,
  input  logic [7:0]  rb_tag,
  input  logic [15:0] rb_data,
  input  logic        rb_last,
  output logic        fifo_wrreq,
  output logic [31:0] fifo_data,
  input  logic        fifo_wrfull,
  output logic        busy,
  output logic [15:0] drop_count,
  output logic [1:0]  dbg_state
);

  // Handshake: an item transfers on a rising edge where rb_valid & rb_ready;
  // rb_valid must stay asserted with stable tag/data/last until that edge.

  localparam logic [7:0] MAX_CNT = 8'(MAX_PAYLOAD);

  state_t      state, state_next;
  logic [7:0]  count, checksum, frame_seq;
  logic        trunc;
  logic        accept, at_max;
  logic        hdr_en, pay_en, trl_en, drop_en, wr_en;
  logic [31:0] wr_word;

  function automatic logic [7:0] fold_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  assign accept    = rb_valid & rb_ready;
  assign at_max    = (count == MAX_CNT);
  assign dbg_state = state;

  always_ff @(posedge sys_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (rb_valid && !fifo_wrfull) state_next = ST_PAYLOAD;
      ST_PAYLOAD: if (accept && rb_last)        state_next = ST_TRAILER;
                  else if (accept && at_max)    state_next = ST_DISCARD;
      ST_DISCARD: if (accept && rb_last)        state_next = ST_TRAILER;
      ST_TRAILER: if (!fifo_wrfull)             state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rb_ready = 1'b0;
    busy     = (state != ST_IDLE);
    hdr_en   = 1'b0;
    pay_en   = 1'b0;
    trl_en   = 1'b0;
    drop_en  = 1'b0;
    wr_word  = 32'h0;
    case (state)
      ST_IDLE: begin
        hdr_en  = rb_valid & ~fifo_wrfull;
        wr_word = {HDR_MARK, frame_seq, 16'h0000};
      end
      ST_PAYLOAD: begin
        rb_ready = ~fifo_wrfull;
        pay_en   = accept & ~at_max;
        drop_en  = accept & at_max;
        wr_word  = {rb_tag, count, rb_data};
      end
      ST_DISCARD: begin
        // Overflow items are swallowed even while the FIFO is full.
        rb_ready = 1'b1;
        drop_en  = accept;
      end
      ST_TRAILER: begin
        trl_en  = ~fifo_wrfull;
        wr_word = {TRL_MARK | {7'b0, trunc}, frame_seq, count, checksum};
      end
      default: ;
    endcase
    wr_en = hdr_en | pay_en | trl_en;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      fifo_wrreq <= 1'b0;
      fifo_data  <= 32'h0;
      count      <= 8'h0;
      checksum   <= 8'h0;
      frame_seq  <= 8'h0;
      trunc      <= 1'b0;
      drop_count <= 16'h0;
    end else begin
      fifo_wrreq <= wr_en;
      if (wr_en) fifo_data <= wr_word;
      if (hdr_en) begin
        count    <= 8'h0;
        checksum <= 8'h0;
        trunc    <= 1'b0;
      end
      if (pay_en) begin
        count    <= count + 8'd1;
        checksum <= checksum ^ fold_bytes(wr_word);
      end
      if (drop_en) begin
        trunc <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (trl_en) begin
        frame_seq <= frame_seq + 8'd1;
        trunc     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_readback_framer.sv
// Bench for readback_framer: table-driven frame plus hand-written sequences
// for truncation, stall, sequence wrap and mid-frame reset.
module tb_readback_framer;
  import readback_framer_pkg::*;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        rb_valid;
  logic        rb_ready;
  logic [7:0]  rb_tag;
  logic [15:0] rb_data;
  logic        rb_last;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic        fifo_wrfull;
  logic        busy;
  logic [15:0] drop_count;
  logic [1:0]  dbg_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_seq;

  typedef struct {
    logic [7:0]  tag;
    logic [15:0] data;
    logic        last;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[3];

  readback_framer #(.MAX_PAYLOAD(4)) dut (
    .sys_clk(sys_clk), .reset(reset), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .rb_tag(rb_tag), .rb_data(rb_data), .rb_last(rb_last),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_wrfull(fifo_wrfull),
    .busy(busy), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic logic [7:0] fold(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  // Scoreboard: every word the DUT writes must be the next expected one.
  always @(negedge sys_clk) begin
    if (fifo_wrreq === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_word: got %08h expected none", fifo_data);
      end else begin
        check("fifo_word", fifo_data, exp_q.pop_front());
      end
    end
  end

  // Entered and left at posedge+1; returns after the accepting edge.
  task automatic send_item(input logic [7:0] tag, input logic [15:0] data, input logic last);
    int n;
    rb_valid = 1'b1; rb_tag = tag; rb_data = data; rb_last = last;
    n = 0;
    @(negedge sys_clk);
    while (rb_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge sys_clk);
    end
    if (n >= 100) begin
      chk_cnt++;
      $display("FAIL accept_timeout: got rb_ready=%0b expected 1", rb_ready);
    end
    @(posedge sys_clk); #1;
    rb_valid = 1'b0; rb_last = 1'b0;
  endtask

  task automatic one_item_frame(input logic [7:0] tag, input logic [15:0] data);
    logic [31:0] pw;
    pw = {tag, 8'h00, data};
    exp_q.push_back({8'hA5, exp_seq, 16'h0000});
    exp_q.push_back(pw);
    exp_q.push_back({8'h5A, exp_seq, 8'h01, fold(pw)});
    send_item(tag, data, 1'b1);
    exp_seq++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge sys_clk); #1;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] pw;
    logic [7:0]  cks;
    logic [15:0] d;

    vecs[0] = '{8'h01, 16'h1111, 1'b0, 32'h01001111};
    vecs[1] = '{8'h02, 16'h2222, 1'b0, 32'h02012222};
    vecs[2] = '{8'h03, 16'h3333, 1'b1, 32'h03023333};

    reset = 1'b1; rb_valid = 1'b0; rb_tag = '0; rb_data = '0; rb_last = 1'b0;
    fifo_wrfull = 1'b0; exp_seq = 8'h00;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_rb_ready", rb_ready, 0);
    check("rst_wrreq", fifo_wrreq, 0);
    check("rst_data", fifo_data, 32'h0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge sys_clk); #1;
    reset = 1'b0;
    @(posedge sys_clk); #1;

    // Three-item frame from the vector table.
    exp_q.push_back(32'hA5000000);
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_word);
    exp_q.push_back(32'h5A000303);
    for (int i = 0; i < 3; i++) send_item(vecs[i].tag, vecs[i].data, vecs[i].last);
    exp_seq++;
    repeat (2) @(posedge sys_clk); #1;
    check("busy_after_frame", busy, 0);
    wait_drain();

    // All-ones single item: checksum FF.
    exp_q.push_back({8'hA5, exp_seq, 16'h0000});
    exp_q.push_back(32'hFF00FFFF);
    exp_q.push_back({8'h5A, exp_seq, 16'h01FF});
    send_item(8'hFF, 16'hFFFF, 1'b1);
    exp_seq++;
    wait_drain();

    // Truncation: 7 items into a 4-word frame.
    cks = 8'h00;
    exp_q.push_back({8'hA5, exp_seq, 16'h0000});
    for (int i = 0; i < 7; i++) begin
      d = 16'($urandom_range(0, 65535));
      if (i < 4) begin
        pw = {8'h10 + 8'(i), 8'(i), d};
        exp_q.push_back(pw);
        cks = cks ^ fold(pw);
      end
      if (i == 6) exp_q.push_back({8'h5B, exp_seq, 8'h04, cks});
      send_item(8'h10 + 8'(i), d, i == 6);
      if (i == 4) check("discard_state", dbg_state, ST_DISCARD);
    end
    exp_seq++;
    wait_drain();
    check("drop_count", drop_count, 3);

    // Stall: wrfull high for 5 cycles with item 2 pending.
    cks = 8'h00;
    exp_q.push_back({8'hA5, exp_seq, 16'h0000});
    for (int i = 0; i < 4; i++) begin
      pw = {8'h20 + 8'(i), 8'(i), 16'hA000 + 16'(i)};
      exp_q.push_back(pw);
      cks = cks ^ fold(pw);
    end
    exp_q.push_back({8'h5A, exp_seq, 8'h04, cks});
    send_item(8'h20, 16'hA000, 1'b0);
    send_item(8'h21, 16'hA001, 1'b0);
    rb_valid = 1'b1; rb_tag = 8'h22; rb_data = 16'hA002; fifo_wrfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      check("stall_rb_ready", rb_ready, 0);
      if (k > 0) check("stall_wrreq", fifo_wrreq, 0);
      @(posedge sys_clk); #1;
    end
    check("stall_state", dbg_state, ST_PAYLOAD);
    fifo_wrfull = 1'b0;
    send_item(8'h22, 16'hA002, 1'b0);
    send_item(8'h23, 16'hA003, 1'b1);
    exp_seq++;
    wait_drain();

    // Single-item frames until the sequence number wraps past 255.
    for (int f = 0; f < 256; f++)
      one_item_frame(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
    wait_drain();

    // Reset after header and two payload words: no trailer follows.
    exp_q.push_back({8'hA5, exp_seq, 16'h0000});
    exp_q.push_back(32'h30005555);
    exp_q.push_back(32'h31016666);
    send_item(8'h30, 16'h5555, 1'b0);
    send_item(8'h31, 16'h6666, 1'b0);
    reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge sys_clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_drop", drop_count, 0);
    check("midrst_queue", exp_q.size(), 0);
    exp_seq = 8'h00;
    one_item_frame(8'h44, 16'h0F0F);
    wait_drain();

    repeat (4) @(posedge sys_clk); #1;
    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
